// File: rtl/seq_ctrl_pkg.sv
// Shared types and constants for the step-sequence controller.
// Defines the FSM state encoding, default widths and the power-on table contents.
package seq_ctrl_pkg;

  localparam int SEQ_W       = 4;
  localparam int SEQ_PRESC_W = 8;
  localparam int SEQ_LOOP_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Power-on next-value entry: a plain binary up-count that wraps at 2**width.
  function automatic int reset_entry(input int idx, input int width);
    return (idx + 1) % (1 << width);
  endfunction

endpackage

// File: rtl/seq_step_controller_prescaler.sv
// Tick generator for the RUN state: counts to prescale and fires one tick.
// hold freezes the count, and clear restarts it from zero.
module seq_prescaler
  import seq_ctrl_pkg::*;
#(
  parameter int PRESC_W = SEQ_PRESC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               enable,
  input  logic               hold,
  input  logic [PRESC_W-1:0] prescale,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt;

  assign tick = enable && !hold && !clear && (cnt == prescale);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !hold) begin
      cnt <= (cnt == prescale) ? '0 : cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/seq_step_controller.sv
// Programmable step-sequence controller: writable next-value table, prescaled
// stepping, loop counting back to start_val, and start/stop/single-step commands.
module seq_step_controller
  import seq_ctrl_pkg::*;
#(
  parameter int W       = SEQ_W,
  parameter int PRESC_W = SEQ_PRESC_W,
  parameter int LOOP_W  = SEQ_LOOP_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [W-1:0]       cfg_addr,
  input  logic [W-1:0]       cfg_data,
  input  logic [W-1:0]       start_val,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [LOOP_W-1:0]  loop_count,
  input  logic               cmd_start,
  input  logic               cmd_stop,
  input  logic               cmd_step,
  output logic [W-1:0]       count,
  output logic               step_pulse,
  output logic               wrap,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  localparam int DEPTH = 2 ** W;

  state_t            state;
  logic [W-1:0]      tbl [DEPTH];
  logic [LOOP_W-1:0] loops;
  logic [LOOP_W-1:0] loops_inc;
  logic [W-1:0]      nxt;
  logic              in_run;
  logic              start_ok;
  logic              step_ok;
  logic              tick;

  assign nxt       = tbl[count];
  assign in_run    = (state == ST_RUN);
  assign loops_inc = (&loops) ? loops : loops + LOOP_W'(1);

  // stop outranks start, which outranks step; a losing command is simply dropped
  assign start_ok = cmd_start && !cmd_stop && !in_run;
  assign step_ok  = cmd_step && !cmd_start && !cmd_stop &&
                    ((state == ST_IDLE) || (state == ST_PAUSE));

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  seq_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (start_ok),
    .enable   (in_run),
    .hold     (cmd_stop),
    .prescale (prescale),
    .tick     (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i[W-1:0]] <= W'(reset_entry(i, W));
      end
    end else if (cfg_we && !in_run) begin
      tbl[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      count      <= '0;
      loops      <= '0;
      step_pulse <= 1'b0;
      wrap       <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      wrap       <= 1'b0;
      cfg_err    <= cfg_we && in_run;

      if (step_ok) begin
        count      <= nxt;
        step_pulse <= 1'b1;
        wrap       <= (nxt == start_val);
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          if (cmd_stop) begin
            state <= ST_IDLE;
          end else if (start_ok) begin
            count <= start_val;
            loops <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (cmd_stop) begin
            state <= ST_PAUSE;
          end else if (tick) begin
            count      <= nxt;
            step_pulse <= 1'b1;
            if (nxt == start_val) begin
              wrap  <= 1'b1;
              loops <= loops_inc;
              // a table that never revisits start_val never reaches this
              if ((loop_count != '0) && (loops_inc == loop_count)) begin
                state <= ST_DONE;
              end
            end
          end
        end
        ST_PAUSE: begin
          if (cmd_stop) begin
            state <= ST_IDLE;
          end else if (start_ok) begin
            state <= ST_RUN;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_step_controller.sv
// Scoreboard bench for seq_step_controller: a reference table predicts every
// step (value, wrap flag and cycle), and a monitor checks each step_pulse.
module tb_seq_step_controller;

  localparam int W       = 4;
  localparam int PRESC_W = 8;
  localparam int LOOP_W  = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               cfg_we = 1'b0;
  logic [W-1:0]       cfg_addr = '0;
  logic [W-1:0]       cfg_data = '0;
  logic [W-1:0]       start_val = '0;
  logic [PRESC_W-1:0] prescale = '0;
  logic [LOOP_W-1:0]  loop_count = '0;
  logic               cmd_start = 1'b0;
  logic               cmd_stop = 1'b0;
  logic               cmd_step = 1'b0;
  logic [W-1:0]       count;
  logic               step_pulse;
  logic               wrap;
  logic               busy;
  logic               done;
  logic               cfg_err;

  seq_step_controller #(.W(W), .PRESC_W(PRESC_W), .LOOP_W(LOOP_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .start_val  (start_val),
    .prescale   (prescale),
    .loop_count (loop_count),
    .cmd_start  (cmd_start),
    .cmd_stop   (cmd_stop),
    .cmd_step   (cmd_step),
    .count      (count),
    .step_pulse (step_pulse),
    .wrap       (wrap),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] cnt;
    logic         wr;
    int           at;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] ref_tbl [16];
  logic [W-1:0] mc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // every step_pulse must match the oldest prediction
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (step_pulse) begin
      if (sb.size() == 0) begin
        check("unexpected_step", 32'(count), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("step_count", 32'(count), 32'(e.cnt));
        check("step_wrap", 32'(wrap), 32'(e.wr));
        check("step_cycle", cyc, e.at);
      end
    end else if (wrap) begin
      check("wrap_without_step", 32'(wrap), 32'd0);
    end
  end

  task automatic ref_reset();
    logic [W-1:0] idx;
    for (int i = 0; i < 16; i++) begin
      idx = W'(i);
      ref_tbl[idx] = idx + W'(1);
    end
    mc = '0;
  endtask

  task automatic next_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_step_pulse", 32'(step_pulse), 32'd0);
    check("rst_wrap", 32'(wrap), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    ref_reset();
    next_cyc(1);
  endtask

  // predict n RUN steps from 'from', starting after a start driven in cycle k
  task automatic push_run(input logic [W-1:0] from, input int n, input int k, input int p);
    logic [W-1:0] c;
    c = from;
    for (int i = 1; i <= n; i++) begin
      c = ref_tbl[c];
      sb.push_back('{c, (c == start_val), k + 2 + p + (i - 1) * (p + 1)});
    end
    mc = c;
  endtask

  task automatic pulse_start();
    cmd_start = 1'b1;
    next_cyc(1);
    cmd_start = 1'b0;
  endtask

  task automatic do_step();
    sb.push_back('{ref_tbl[mc], (ref_tbl[mc] == start_val), cyc + 1});
    mc = ref_tbl[mc];
    cmd_step = 1'b1;
    next_cyc(1);
    cmd_step = 1'b0;
    next_cyc(1);
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    check(tag, sb.size(), 32'd0);
    sb.delete();
  endtask

  task automatic write_cfg(input logic [W-1:0] a, input logic [W-1:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    next_cyc(1);
    cfg_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int k;
    logic [W-1:0] seqv [16];
    seqv = '{4'd1, 4'd3, 4'd5, 4'd0, 4'd2, 4'd4, 4'd6, 4'd7,
             4'd8, 4'd9, 4'd10, 4'd15, 4'd14, 4'd13, 4'd12, 4'd11};
    #2;
    do_reset();

    // default table, two loops at full rate, then one more loop from DONE
    start_val = 4'd0; prescale = 8'd0; loop_count = 8'd2;
    k = cyc;
    push_run(start_val, 32, k, 0);
    pulse_start();
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_count_start", 32'(count), 32'd0);
    drain("t1_drain", 100);
    check("t1_done", 32'(done), 32'd1);
    check("t1_done_count", 32'(count), 32'd0);
    check("t1_done_busy", 32'(busy), 32'd0);
    loop_count = 8'd1;
    k = cyc;
    push_run(start_val, 16, k, 0);
    pulse_start();
    check("t1_restart_busy", 32'(busy), 32'd1);
    drain("t1_restart_drain", 60);
    check("t1_restart_done", 32'(done), 32'd1);
    cmd_stop = 1'b1;
    next_cyc(1);
    cmd_stop = 1'b0;
    check("t1_clear_done", 32'(done), 32'd0);

    // custom cyclic table, prescale 2, run forever
    for (int i = 0; i < 16; i++) begin
      ref_tbl[seqv[i[3:0]]] = seqv[4'(i + 1)];
      write_cfg(seqv[i[3:0]], seqv[4'(i + 1)]);
    end
    check("t2_cfg_err_idle", 32'(cfg_err), 32'd0);
    start_val = 4'd1; prescale = 8'd2; loop_count = 8'd0;
    k = cyc;
    push_run(start_val, 34, k, 2);
    pulse_start();
    check("t2_count_start", 32'(count), 32'd1);
    drain("t2_drain", 200);
    check("t2_still_busy", 32'(busy), 32'd1);
    check("t2_not_done", 32'(done), 32'd0);
    cmd_stop = 1'b1;
    next_cyc(1);
    check("t2_pause_busy", 32'(busy), 32'd0);
    check("t2_pause_count", 32'(count), 32'(mc));
    next_cyc(1);
    cmd_stop = 1'b0;

    // prescale 3: pause one cycle before a tick, resume, then a combined command
    do_reset();
    start_val = 4'd0; prescale = 8'd3; loop_count = 8'd0;
    do_step();
    drain("t3_idle_step", 5);
    k = cyc;
    push_run(start_val, 2, k, 3);
    pulse_start();
    check("t3_count_start", 32'(count), 32'd0);
    drain("t3_drain", 30);
    next_cyc(2);
    cmd_stop = 1'b1;
    next_cyc(1);
    cmd_stop = 1'b0;
    check("t3_pause_busy", 32'(busy), 32'd0);
    next_cyc(6);
    check("t3_pause_hold", 32'(count), 32'(mc));
    k = cyc;
    push_run(mc, 1, k, 3);
    pulse_start();
    check("t3_resume_busy", 32'(busy), 32'd1);
    drain("t3_resume_drain", 20);
    cmd_stop = 1'b1; cmd_start = 1'b1; cmd_step = 1'b1;
    next_cyc(1);
    cmd_stop = 1'b0; cmd_start = 1'b0; cmd_step = 1'b0;
    check("t3_combo_busy", 32'(busy), 32'd0);
    next_cyc(5);
    check("t3_combo_count", 32'(count), 32'd3);
    do_step();
    do_step();
    check("t4_count5", 32'(count), 32'd5);
    do_step();
    do_step();
    do_step();
    drain("t4_drain", 5);
    check("t4_count8", 32'(count), 32'd8);
    cmd_stop = 1'b1;
    next_cyc(1);
    cmd_stop = 1'b0;

    // table write rejected in RUN, accepted in IDLE
    start_val = 4'd3; prescale = 8'd7; loop_count = 8'd0;
    k = cyc;
    push_run(start_val, 1, k, 7);
    pulse_start();
    write_cfg(4'd3, 4'd9);
    check("t5_cfg_err_pulse", 32'(cfg_err), 32'd1);
    next_cyc(1);
    check("t5_cfg_err_clear", 32'(cfg_err), 32'd0);
    drain("t5_run_drain", 20);
    check("t5_unchanged", 32'(count), 32'd4);
    cmd_stop = 1'b1;
    next_cyc(2);
    cmd_stop = 1'b0;
    ref_tbl[3] = 4'd9;
    write_cfg(4'd3, 4'd9);
    check("t5_cfg_err_idle", 32'(cfg_err), 32'd0);
    k = cyc;
    push_run(start_val, 1, k, 7);
    pulse_start();
    drain("t5_written_drain", 20);
    check("t5_written", 32'(count), 32'd9);

    // reset while running restores the default table
    #2;
    do_reset();
    check("t6_idle", 32'(busy), 32'd0);
    do_step();
    do_step();
    do_step();
    do_step();
    drain("t6_drain", 5);
    check("t6_restored", 32'(count), 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
